dma_bus_burst_slave: RTL and testbench
======================================

// Module: dma_bus_burst_slave
// PURPOSE
//  Bus responder (target) for DMA burst transactions on the shared system bus. Decodes
//  begin_transaction, accepts write bursts into a local word RAM or returns read bursts
//  from it, with slave-side error reporting. Sits on the bus opposite the DMA initiator,
//  acting as the external memory that the DMA engine moves blocks to and from.
// PARAMETERS
//  BASE_ADDR   32'h5000_0000  byte base address of the window (word aligned)
//  DEPTH_LOG2  10             log2 of RAM depth in 32-bit words (window = 4<<DEPTH_LOG2 bytes)
// PORTS
//  clock                  in   1   system clock, all logic on posedge
//  reset                  in   1   synchronous, active-high
//  begin_transaction_in   in   1   1-cycle strobe: address_data_in holds start byte address
//  end_transaction_in     in   1   initiator ends or aborts the current transaction
//  read_n_write_in        in   1   sampled with begin: 1 = read, 0 = write
//  burst_size_in          in   8   sampled with begin: beats-1 (0 = single beat, 255 = 256 beats)
//  byte_enables_in        in   4   per-beat byte lanes for writes (bit i = bits 8i+7:8i)
//  address_data_in        in   32  address at begin, write data when data_valid_in
//  data_valid_in          in   1   write beat valid
//  busy_in                in   1   initiator stall for read data
//  address_data_out       out  32  read data; 0 whenever data_valid_out=0 (wired-OR bus)
//  data_valid_out         out  1   read beat valid
//  end_transaction_out    out  1   1-cycle strobe after last read beat
//  error_out              out  1   1-cycle strobe: selected burst crosses window end
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, counters 0. RAM contents NOT cleared. Reset mid-burst
//    aborts immediately; no end_transaction_out or error_out is issued.
//  - Selection: start address A selected iff BASE_ADDR <= A < BASE_ADDR + (4<<DEPTH_LOG2).
//    Unselected begin is ignored (stay IDLE, no outputs). Word index = (A-BASE_ADDR)>>2; A[1:0] ignored.
//  - Range: selected and index + burst_size_in >= 2^DEPTH_LOG2 -> ERROR (error_out=1 next cycle), then IDLE.
//  - FSM: IDLE, WRITE, RD_FETCH, READ, RD_END, ERROR.
//    IDLE -> WRITE (rnw=0) | RD_FETCH (rnw=1) | ERROR, on selected begin_transaction_in.
//    begin_transaction_in outside IDLE is ignored.
//  - WRITE: each cycle with data_valid_in=1 writes address_data_in to RAM[index] under
//    byte_enables_in, index+1, remaining-1. No wait states. After beat burst_size_in+1 -> IDLE.
//    Extra data_valid_in beats after completion are ignored.
//  - RD_FETCH: 1 cycle RAM read latency. First data_valid_out is 2 cycles after begin strobe.
//  - READ: one beat per cycle, data_valid_out=1. If busy_in=1 in a cycle where data_valid_out=1,
//    that beat is repeated next cycle with identical data; index does not advance
//    (RAM read address held / prefetched word buffered). After last beat accepted -> RD_END.
//  - RD_END: end_transaction_out=1 for exactly one cycle, data_valid_out=0 -> IDLE.
//  - ERROR: error_out=1 for one cycle -> IDLE. No RAM access.
//  - end_transaction_in in WRITE/RD_FETCH/READ: abort -> IDLE next cycle, outputs 0 that cycle.
//    A write beat presented in the same cycle is still written. No end_transaction_out on abort.
//  - Counters: remaining is 9 bits (max 256 beats). Index never wraps (range check guarantees).
//  - Simultaneous end_transaction_in and last read beat: beat counts, no end_transaction_out.
// TESTING
//  1 write BASE+0x10 burst_size=3, data 0x11..0x44, be=4'hF; read back same -> data_valid_out
//    4 cycles from begin+2, data 0x11,0x22,0x33,0x44, end_transaction_out at begin+6.
//  2 begin at BASE_ADDR-4 and BASE_ADDR+0x1000 (DEPTH_LOG2=10) -> no outputs, FSM stays IDLE.
//  3 read begin at index 1020, burst_size=7 -> error_out=1 at begin+1 only; RAM untouched.
//  4 write be=4'b0101 data 0xAABBCCDD over 0x0 -> readback 0x00BB00DD; busy_in high 2 cycles
//    during 4-beat read -> each held beat repeated, sequence intact, total 6 valid cycles.
//  5 end_transaction_in at 2nd beat of 8-beat read -> outputs 0 next cycle, no end strobe;
//    next begin served normally.
//  6 reset asserted mid 16-beat write after 5 beats -> outputs 0, IDLE; readback shows 5 beats written.

Source files
------------

// File: rtl/dma_bus_burst_slave.sv
// Bus target for DMA burst transfers: decodes a word-RAM window, absorbs write bursts,
// streams read bursts with initiator stall, and flags bursts that would run past the window.
module dma_bus_burst_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic        end_transaction_in,
    input  logic        read_n_write_in,
    input  logic [7:0]  burst_size_in,
    input  logic [3:0]  byte_enables_in,
    input  logic [31:0] address_data_in,
    input  logic        data_valid_in,
    input  logic        busy_in,
    output logic [31:0] address_data_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        error_out
);
    localparam int          DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [31:0] WINDOW = 32'(4 * DEPTH);

    typedef enum logic [2:0] {IDLE, WRITE, RD_FETCH, READ, RD_END, ERROR} state_t;

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   index;
    logic [8:0]              remaining;
    logic [31:0]             ram [DEPTH];

    logic [31:0]             offset;
    logic                    selected;
    logic [DEPTH_LOG2-1:0]   start_index;
    logic [31:0]             last_index;
    logic                    out_of_range;
    logic                    write_beat;

    // The explicit lower-bound test keeps a window near the top of the address map correct.
    assign offset       = address_data_in - BASE_ADDR;
    assign selected     = (address_data_in >= BASE_ADDR) && (offset < WINDOW);
    assign start_index  = offset[DEPTH_LOG2+1:2];
    assign last_index   = 32'(start_index) + 32'(burst_size_in);
    assign out_of_range = last_index >= 32'(DEPTH);
    assign write_beat   = (state == WRITE) && data_valid_in && !reset;

    always_ff @(posedge clock) begin
        if (write_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_enables_in[b])
                    ram[index][8*b +: 8] <= address_data_in[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            index               <= '0;
            remaining           <= '0;
            address_data_out    <= '0;
            data_valid_out      <= 1'b0;
            end_transaction_out <= 1'b0;
            error_out           <= 1'b0;
        end else begin
            end_transaction_out <= 1'b0;
            error_out           <= 1'b0;
            case (state)
                IDLE: begin
                    if (begin_transaction_in && selected) begin
                        index     <= start_index;
                        remaining <= 9'(burst_size_in) + 9'd1;
                        if (out_of_range) begin
                            state     <= ERROR;
                            error_out <= 1'b1;
                        end else begin
                            state <= read_n_write_in ? RD_FETCH : WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (data_valid_in) begin
                        index     <= index + 1'b1;
                        remaining <= remaining - 9'd1;
                    end
                    if (end_transaction_in || (data_valid_in && remaining == 9'd1))
                        state <= IDLE;
                end
                RD_FETCH: begin
                    if (end_transaction_in) begin
                        state <= IDLE;
                    end else begin
                        address_data_out <= ram[index];
                        data_valid_out   <= 1'b1;
                        index            <= index + 1'b1;
                        remaining        <= remaining - 9'd1;
                        state            <= READ;
                    end
                end
                READ: begin
                    // remaining counts beats still to be fetched after the one on the bus.
                    if (end_transaction_in) begin
                        address_data_out <= '0;
                        data_valid_out   <= 1'b0;
                        state            <= IDLE;
                    end else if (!busy_in) begin
                        if (remaining == 9'd0) begin
                            address_data_out    <= '0;
                            data_valid_out      <= 1'b0;
                            end_transaction_out <= 1'b1;
                            state               <= RD_END;
                        end else begin
                            address_data_out <= ram[index];
                            index            <= index + 1'b1;
                            remaining        <= remaining - 9'd1;
                        end
                    end
                end
                RD_END:  state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_bus_burst_slave.sv
// Directed bench for dma_bus_burst_slave: per-scenario tasks with inline expected values.
module tb_dma_bus_burst_slave;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        begin_transaction_in, end_transaction_in, read_n_write_in;
    logic [7:0]  burst_size_in;
    logic [3:0]  byte_enables_in;
    logic [31:0] address_data_in;
    logic        data_valid_in, busy_in;
    logic [31:0] address_data_out;
    logic        data_valid_out, end_transaction_out, error_out;

    int compared   = 0;
    int mismatched = 0;

    // Per-cycle capture of a transaction; index k = cycles after the begin strobe.
    logic        log_dv   [32];
    logic [31:0] log_data [32];
    logic        log_end  [32];
    logic        log_err  [32];
    logic        busy_pat [32];
    logic        abort_pat[32];

    dma_bus_burst_slave dut (
        .clock(clock), .reset(reset),
        .begin_transaction_in(begin_transaction_in), .end_transaction_in(end_transaction_in),
        .read_n_write_in(read_n_write_in), .burst_size_in(burst_size_in),
        .byte_enables_in(byte_enables_in), .address_data_in(address_data_in),
        .data_valid_in(data_valid_in), .busy_in(busy_in),
        .address_data_out(address_data_out), .data_valid_out(data_valid_out),
        .end_transaction_out(end_transaction_out), .error_out(error_out)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_pats;
        for (int k = 0; k < 32; k++) begin
            busy_pat[k]  = 1'b0;
            abort_pat[k] = 1'b0;
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input int bs, input logic [31:0] d0,
                               input logic [31:0] inc, input logic [3:0] be);
        begin_transaction_in = 1'b1;
        read_n_write_in      = 1'b0;
        burst_size_in        = bs[7:0];
        address_data_in      = addr;
        step;
        begin_transaction_in = 1'b0;
        for (int i = 0; i <= bs; i++) begin
            data_valid_in   = 1'b1;
            byte_enables_in = be;
            address_data_in = d0 + inc * 32'(i);
            step;
        end
        data_valid_in   = 1'b0;
        address_data_in = '0;
        step;
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic rnw, input int bs, input int ncyc);
        begin_transaction_in = 1'b1;
        read_n_write_in      = rnw;
        burst_size_in        = bs[7:0];
        address_data_in      = addr;
        step;
        begin_transaction_in = 1'b0;
        address_data_in      = '0;
        for (int k = 1; k <= ncyc; k++) begin
            log_dv[k]          = data_valid_out;
            log_data[k]        = address_data_out;
            log_end[k]         = end_transaction_out;
            log_err[k]         = error_out;
            busy_in            = busy_pat[k];
            end_transaction_in = abort_pat[k];
            step;
        end
        busy_in            = 1'b0;
        end_transaction_in = 1'b0;
        clear_pats;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        compared++;
        if (data_valid_out !== 1'b0) begin
            mismatched++; $display("FAIL reset_dv: got %b want 0", data_valid_out);
        end
        compared++;
        if (address_data_out !== 32'h0) begin
            mismatched++; $display("FAIL reset_data: got %h want 0", address_data_out);
        end
        compared++;
        if (end_transaction_out !== 1'b0 || error_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got end=%b err=%b want 0 0", end_transaction_out, error_out);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_write_read;
        write_burst(BASE + 32'h10, 3, 32'h11, 32'h11, 4'hF);
        run_txn(BASE + 32'h10, 1'b1, 3, 7);
        compared++;
        if (log_dv[1] !== 1'b0) begin
            mismatched++; $display("FAIL wr_rd_fetch_dv: got %b want 0", log_dv[1]);
        end
        for (int k = 2; k <= 5; k++) begin
            compared++;
            if (log_dv[k] !== 1'b1 || log_data[k] !== 32'h11 * 32'(k - 1)) begin
                mismatched++;
                $display("FAIL wr_rd_beat%0d: got dv=%b data=%h want dv=1 data=%h",
                         k - 2, log_dv[k], log_data[k], 32'h11 * 32'(k - 1));
            end
        end
        compared++;
        if (log_end[6] !== 1'b1 || log_dv[6] !== 1'b0 || log_data[6] !== 32'h0) begin
            mismatched++;
            $display("FAIL wr_rd_end: got end=%b dv=%b data=%h want 1 0 0", log_end[6], log_dv[6], log_data[6]);
        end
        compared++;
        if (log_end[7] !== 1'b0) begin
            mismatched++; $display("FAIL wr_rd_end_once: got %b want 0", log_end[7]);
        end
    endtask

    task automatic test_unselected;
        logic [31:0] addrs [2];
        addrs[0] = BASE - 32'h4;
        addrs[1] = BASE + 32'h1000;
        for (int a = 0; a < 2; a++) begin
            run_txn(addrs[a], a == 0, 0, 4);
            for (int k = 1; k <= 4; k++) begin
                compared++;
                if ({log_dv[k], log_end[k], log_err[k]} !== 3'b000 || log_data[k] !== 32'h0) begin
                    mismatched++;
                    $display("FAIL unsel_%h_c%0d: got dv=%b end=%b err=%b data=%h want all 0",
                             addrs[a], k, log_dv[k], log_end[k], log_err[k], log_data[k]);
                end
            end
        end
        run_txn(BASE + 32'h10, 1'b1, 0, 3);
        compared++;
        if (log_dv[2] !== 1'b1 || log_data[2] !== 32'h11 || log_end[3] !== 1'b1) begin
            mismatched++;
            $display("FAIL unsel_then_read: got dv=%b data=%h end=%b want 1 00000011 1",
                     log_dv[2], log_data[2], log_end[3]);
        end
    endtask

    task automatic test_range_error;
        write_burst(BASE + 32'hFF0, 3, 32'hA0, 32'h1, 4'hF);
        for (int t = 0; t < 2; t++) begin
            run_txn(BASE + 32'hFF0, t == 0, (t == 0) ? 7 : 4, 4);
            compared++;
            if (log_err[1] !== 1'b1 || log_err[2] !== 1'b0 || log_err[3] !== 1'b0) begin
                mismatched++;
                $display("FAIL range_err%0d: got err=%b%b%b want 100", t, log_err[1], log_err[2], log_err[3]);
            end
            compared++;
            if ({log_dv[1], log_dv[2], log_dv[3], log_end[2], log_end[3]} !== 5'b0) begin
                mismatched++; $display("FAIL range_quiet%0d: got bus activity want none", t);
            end
        end
        run_txn(BASE + 32'hFF0, 1'b1, 3, 6);
        for (int k = 2; k <= 5; k++) begin
            compared++;
            if (log_dv[k] !== 1'b1 || log_data[k] !== 32'hA0 + 32'(k - 2) || log_err[k] !== 1'b0) begin
                mismatched++;
                $display("FAIL range_edge_beat%0d: got dv=%b data=%h err=%b want 1 %h 0",
                         k - 2, log_dv[k], log_data[k], log_err[k], 32'hA0 + 32'(k - 2));
            end
        end
        compared++;
        if (log_end[6] !== 1'b1) begin
            mismatched++; $display("FAIL range_edge_end: got %b want 1", log_end[6]);
        end
        run_txn(BASE + 32'hFFC, 1'b1, 0, 3);
        compared++;
        if (log_err[1] !== 1'b0 || log_dv[2] !== 1'b1 || log_data[2] !== 32'hA3) begin
            mismatched++;
            $display("FAIL range_last_word: got err=%b dv=%b data=%h want 0 1 000000a3",
                     log_err[1], log_dv[2], log_data[2]);
        end
    endtask

    task automatic test_be_busy;
        logic [31:0] exp [8];
        int          nvalid;
        write_burst(BASE, 3, 32'h0, 32'h101, 4'hF);
        write_burst(BASE, 0, 32'hAABB_CCDD, 32'h0, 4'b0101);
        exp[2] = 32'h00BB_00DD; exp[3] = 32'h101; exp[4] = 32'h101;
        exp[5] = 32'h101;       exp[6] = 32'h202; exp[7] = 32'h303;
        busy_pat[3] = 1'b1;
        busy_pat[4] = 1'b1;
        run_txn(BASE, 1'b1, 3, 9);
        nvalid = 0;
        for (int k = 2; k <= 7; k++) begin
            compared++;
            if (log_dv[k] !== 1'b1 || log_data[k] !== exp[k]) begin
                mismatched++;
                $display("FAIL busy_c%0d: got dv=%b data=%h want 1 %h", k, log_dv[k], log_data[k], exp[k]);
            end
        end
        for (int k = 1; k <= 9; k++) nvalid += int'(log_dv[k]);
        compared++;
        if (nvalid !== 6) begin
            mismatched++; $display("FAIL busy_valid_count: got %0d want 6", nvalid);
        end
        compared++;
        if (log_end[8] !== 1'b1 || log_end[7] !== 1'b0 || log_dv[8] !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_end: got end7=%b end8=%b dv8=%b want 0 1 0", log_end[7], log_end[8], log_dv[8]);
        end
    endtask

    task automatic test_abort;
        abort_pat[3] = 1'b1;
        run_txn(BASE, 1'b1, 7, 6);
        compared++;
        if (log_dv[3] !== 1'b1 || log_data[3] !== 32'h101) begin
            mismatched++; $display("FAIL abort_beat1: got dv=%b data=%h want 1 00000101", log_dv[3], log_data[3]);
        end
        for (int k = 4; k <= 6; k++) begin
            compared++;
            if (log_dv[k] !== 1'b0 || log_data[k] !== 32'h0 || log_end[k] !== 1'b0) begin
                mismatched++;
                $display("FAIL abort_c%0d: got dv=%b data=%h end=%b want 0 0 0", k, log_dv[k], log_data[k], log_end[k]);
            end
        end
        abort_pat[2] = 1'b1;
        run_txn(BASE + 32'h10, 1'b1, 0, 4);
        compared++;
        if (log_dv[2] !== 1'b1 || log_data[2] !== 32'h11 || log_end[3] !== 1'b0 || log_dv[3] !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_last_beat: got dv2=%b data=%h end3=%b dv3=%b want 1 00000011 0 0",
                     log_dv[2], log_data[2], log_end[3], log_dv[3]);
        end
        run_txn(BASE + 32'h10, 1'b1, 1, 5);
        compared++;
        if (log_data[2] !== 32'h11 || log_data[3] !== 32'h22 || log_end[4] !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_next_txn: got %h %h end=%b want 00000011 00000022 1",
                     log_data[2], log_data[3], log_end[4]);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] want;
        write_burst(BASE + 32'h100, 5, 32'h0, 32'h0, 4'hF);
        begin_transaction_in = 1'b1;
        read_n_write_in      = 1'b0;
        burst_size_in        = 8'd15;
        address_data_in      = BASE + 32'h100;
        step;
        begin_transaction_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_valid_in   = 1'b1;
            byte_enables_in = 4'hF;
            address_data_in = 32'hC0 + 32'(i);
            step;
        end
        data_valid_in = 1'b0;
        reset         = 1'b1;
        step;
        compared++;
        if ({data_valid_out, end_transaction_out, error_out} !== 3'b000 || address_data_out !== 32'h0) begin
            mismatched++; $display("FAIL midwr_reset_outputs: got activity want all 0");
        end
        reset           = 1'b0;
        data_valid_in   = 1'b1;
        address_data_in = 32'hEE;
        step;
        data_valid_in   = 1'b0;
        address_data_in = '0;
        step;
        run_txn(BASE + 32'h100, 1'b1, 5, 9);
        for (int k = 2; k <= 7; k++) begin
            want = (k <= 6) ? 32'hC0 + 32'(k - 2) : 32'h0;
            compared++;
            if (log_dv[k] !== 1'b1 || log_data[k] !== want) begin
                mismatched++;
                $display("FAIL midwr_word%0d: got dv=%b data=%h want 1 %h", k - 2, log_dv[k], log_data[k], want);
            end
        end
        compared++;
        if (log_end[8] !== 1'b1) begin
            mismatched++; $display("FAIL midwr_end: got %b want 1", log_end[8]);
        end
    endtask

    initial begin
        reset = 1'b1;
        begin_transaction_in = 1'b0; end_transaction_in = 1'b0; read_n_write_in = 1'b0;
        burst_size_in = '0; byte_enables_in = '0; address_data_in = '0;
        data_valid_in = 1'b0; busy_in = 1'b0;
        clear_pats;
        test_reset;
        test_write_read;
        test_unselected;
        test_range_error;
        test_be_busy;
        test_abort;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
